key_event_gen: RTL

//  Converts one raw asynchronous push-button (DE2-115 KEY[n]) into clean single-cycle

---
 rtl/key_event_if.sv | 31 +++
 rtl/key_event_gen.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/key_event_if.sv
// Signal bundle between one push-button conditioner and its consumer.
// slave = conditioner side, master = the side driving the key and consuming events.
interface key_event_if;
  logic key_async;
  logic repeat_en;
  logic pressed;
  logic press_event;
  logic release_event;
  logic repeat_event;
  logic key_event;

  modport slave (
    input  key_async,
    input  repeat_en,
    output pressed,
    output press_event,
    output release_event,
    output repeat_event,
    output key_event
  );

  modport master (
    output key_async,
    output repeat_en,
    input  pressed,
    input  press_event,
    input  release_event,
    input  repeat_event,
    input  key_event
  );
endinterface

// File: rtl/key_event_gen.sv
// Push-button conditioner: synchronise, debounce, and emit press/release
// pulses plus hold-to-repeat ticks for one raw key.
module key_event_gen #(
  parameter bit          ACTIVE_LOW           = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  key_event_if.slave  bus
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                 REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD_CYCLES - 1);
  localparam logic          PIN_IDLE = ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic [DW-1:0] db_cnt_q;
  logic [TW-1:0] timer_q;
  state_e        state_q;
  logic          press_q;
  logic          release_q;
  logic          repeat_q;
  logic          key_q;

  logic          raw_s;
  logic          accept_s;

  // Normalise polarity and flag the cycle a level change is accepted.
  always_comb begin
    raw_s    = ACTIVE_LOW ? ~sync2_q : sync2_q;
    accept_s = 1'b0;
    if ((raw_s != stable_q) && (db_cnt_q == DB_LAST)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Synchroniser and debouncer; sync FFs reset to the released pin level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= PIN_IDLE;
      sync2_q  <= PIN_IDLE;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= bus.key_async;
      sync2_q <= sync1_q;
      if (raw_s == stable_q) begin
        db_cnt_q <= '0;
      end else if (accept_s) begin
        stable_q <= ~stable_q;
        db_cnt_q <= '0;
      end else if (db_cnt_q < DB_LAST) begin
        db_cnt_q <= db_cnt_q + DW'(1);
      end else begin
        db_cnt_q <= db_cnt_q;
      end
    end
  end

  // Event FSM; reacts to the accept strobe so events line up with stable_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      key_q     <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      key_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (accept_s && !stable_q) begin
            press_q <= 1'b1;
            key_q   <= 1'b1;
            state_q <= ST_HELD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HELD: begin
          // Release takes priority over a coincident timer expiry.
          if (accept_s && stable_q) begin
            release_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= ST_IDLE;
          end else if (timer_q == DLY_LAST) begin
            if (bus.repeat_en) begin
              repeat_q <= 1'b1;
              key_q    <= 1'b1;
              timer_q  <= '0;
              state_q  <= ST_REPEAT;
            end else begin
              timer_q <= timer_q;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_REPEAT: begin
          if (accept_s && stable_q) begin
            release_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= ST_IDLE;
          end else if (!bus.repeat_en) begin
            timer_q <= timer_q;
          end else if (timer_q == PER_LAST) begin
            repeat_q <= 1'b1;
            key_q    <= 1'b1;
            timer_q  <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign bus.pressed       = stable_q;
  assign bus.press_event   = press_q;
  assign bus.release_event = release_q;
  assign bus.repeat_event  = repeat_q;
  assign bus.key_event     = key_q;

endmodule
